enc_home_ctrl: RTL
==================

ENC_HOME_CTRL -- requirements
Module: enc_home_ctrl

Interface
REQ-001 SHALL have parameter POS_W, default 16, position counter width in bits.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 100000000, SEEK timeout in clock cycles (1 s at 100 MHz).
REQ-003 SHALL have port I_CLK_100MHZ  in  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port I_RST_N  in  1  one clock; reset asynchronous, active-low.
REQ-005 SHALL have ports I_ENC_A, I_ENC_B, I_ENC_Z  in  1 each  debounced encoder channels, already in I_CLK_100MHZ domain.
REQ-006 SHALL have port I_HOME_REQ  in  1  single-cycle pulse, start homing.
REQ-007 SHALL have port I_ABORT  in  1  level, cancel homing / clear fault.
REQ-008 SHALL have port O_POS  out  POS_W  signed two's-complement position.
REQ-009 SHALL have port O_DIR  out  1  direction of last valid step, 1 = up.
REQ-010 SHALL have ports O_BUSY, O_HOMED, O_FAULT  out  1 each  homing status flags.
REQ-011 SHALL have port O_STATE  out  2  FSM state code for LED display.
REQ-012 SHALL have port O_ERR_CNT  out  8  illegal-transition count, saturating.

Function
REQ-013 SHALL register A/B/Z once (stage s1) and keep previous sample (s2); edges derived from s1 vs s2 only.
REQ-014 SHALL decode x4 quadrature: AB 00->01->11->10->00 = +1, reverse = -1, O_DIR updated on each valid step.
REQ-015 SHALL treat both A and B changing in one cycle as illegal: no count, O_ERR_CNT +1, saturate at 255.
REQ-016 SHALL reflect an A/B pin change on O_POS exactly 2 cycles later.
REQ-017 SHALL count in every FSM state; O_POS wraps modulo 2^POS_W (0x7FFF +1 -> 0x8000; 0x0000 -1 -> 0xFFFF).
REQ-018 SHALL ignore A/B/Z edges in the first cycle after reset release (history seeding, no count, no error).
REQ-019 SHALL implement FSM IDLE(00), SEEK(01), HOMED(10), FAULT(11); O_STATE = code.
REQ-020 SHALL go IDLE/HOMED/FAULT -> SEEK on I_HOME_REQ: timer cleared, O_HOMED=0, O_FAULT=0, O_BUSY=1.
REQ-021 SHALL ignore I_HOME_REQ while in SEEK (timer not restarted).
REQ-022 SHALL go SEEK -> HOMED on Z rising edge: O_POS=0 that cycle, O_HOMED=1, O_BUSY=0.
REQ-023 SHALL, on Z edge coincident with a valid A/B step in SEEK, load 0 and discard the step.
REQ-024 SHALL go SEEK -> FAULT when timer reaches TIMEOUT_CYC-1 with no Z edge: O_FAULT=1, O_BUSY=0.
REQ-025 SHALL go SEEK -> IDLE on I_ABORT; abort wins over coincident Z edge or timeout.
REQ-026 SHALL go FAULT -> IDLE on I_ABORT, clearing O_FAULT; I_ABORT ignored in IDLE/HOMED.
REQ-027 SHALL not re-zero O_POS on Z edges outside SEEK.
REQ-028 SHALL give I_HOME_REQ priority over I_ABORT in IDLE/HOMED/FAULT only when I_ABORT is low; both high in FAULT -> IDLE.

Reset
REQ-029 SHALL, while I_RST_N=0, force O_POS=0, O_DIR=0, O_BUSY=0, O_HOMED=0, O_FAULT=0, O_ERR_CNT=0, state IDLE, timer 0, s1/s2=0.
REQ-030 SHALL abandon any homing in progress on reset with no residual flag set.

Structure
REQ-031 SHALL take state codes and default TIMEOUT_CYC from shared package enc_ctrl_pkg.
REQ-032 SHALL contain one sub-module quad_decoder (s1/s2 registers, step/dir/illegal/Z-edge outputs); FSM, timer, counter in top.

Verification (TIMEOUT_CYC=1000 in sim)
REQ-033 SHALL check 8 forward Gray steps from reset -> O_POS=8, O_DIR=1; then 10 reverse -> O_POS=0xFFFE, O_DIR=0.
REQ-034 SHALL check HOME_REQ, 5 steps, Z pulse -> O_POS=0, O_HOMED=1, O_STATE=10, O_BUSY=0.
REQ-035 SHALL check HOME_REQ with no Z for 1000 cycles -> O_FAULT=1, O_STATE=11; I_ABORT -> O_STATE=00, O_FAULT=0.
REQ-036 SHALL check AB 00->11 300 times -> O_ERR_CNT=255, O_POS unchanged.
REQ-037 SHALL check I_RST_N pulled low mid-SEEK -> all outputs 0 asynchronously; A=B=1 at release -> no count.
REQ-038 SHALL check Z edge and I_ABORT same cycle in SEEK -> IDLE, O_HOMED=0, O_POS not zeroed.

Source files
------------

// File: rtl/enc_ctrl_pkg.sv
// enc_ctrl_pkg: shared homing FSM state codes and default SEEK timeout.
// Revision 1.0
`default_nettype none

package enc_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SEEK  = 2'b01,
    ST_HOMED = 2'b10,
    ST_FAULT = 2'b11
  } home_state_e;

  // One second at 100 MHz
  localparam int unsigned TIMEOUT_CYC_DEF = 100_000_000;

endpackage

`default_nettype wire

// File: rtl/quad_decoder.sv
// quad_decoder: samples A/B/Z, flags x4 quadrature steps, illegal jumps and Z rising edges.
// Revision 1.0
`default_nettype none

module quad_decoder (
  input  logic clk,
  input  logic rst_n,
  input  logic enc_a,
  input  logic enc_b,
  input  logic enc_z,
  output logic step,
  output logic step_up,
  output logic illegal,
  output logic z_rise
);

  logic [2:0] s1_q, s1_d;
  logic [2:0] s2_q, s2_d;
  logic       seed_q, seed_d;
  logic       hist_ok_q, hist_ok_d;
  logic [1:0] ab_chg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q      <= '0;
      s2_q      <= '0;
      seed_q    <= 1'b0;
      hist_ok_q <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      seed_q    <= seed_d;
      hist_ok_q <= hist_ok_d;
    end
  end

  // Edges are trusted only once s2 holds a real pin sample rather than the reset value.
  always_comb begin
    s1_d      = {enc_a, enc_b, enc_z};
    s2_d      = s1_q;
    seed_d    = 1'b1;
    hist_ok_d = seed_q;
    ab_chg    = s1_q[2:1] ^ s2_q[2:1];
    step      = hist_ok_q & ((ab_chg == 2'b01) | (ab_chg == 2'b10));
    illegal   = hist_ok_q & (ab_chg == 2'b11);
    // Sequence 00->01->11->10 counts up exactly when previous A differs from current B.
    step_up   = s2_q[2] ^ s1_q[1];
    z_rise    = hist_ok_q & s1_q[0] & ~s2_q[0];
  end

endmodule

`default_nettype wire

// File: rtl/enc_home_ctrl.sv
// enc_home_ctrl: quadrature position counter with Z-index homing FSM, SEEK timeout and error count.
// Revision 1.0
`default_nettype none

module enc_home_ctrl
  import enc_ctrl_pkg::*;
#(
  parameter int          POS_W       = 16,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                    I_CLK_100MHZ,
  input  logic                    I_RST_N,
  input  logic                    I_ENC_A,
  input  logic                    I_ENC_B,
  input  logic                    I_ENC_Z,
  input  logic                    I_HOME_REQ,
  input  logic                    I_ABORT,
  output logic signed [POS_W-1:0] O_POS,
  output logic                    O_DIR,
  output logic                    O_BUSY,
  output logic                    O_HOMED,
  output logic                    O_FAULT,
  output logic [1:0]              O_STATE,
  output logic [7:0]              O_ERR_CNT
);

  localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  home_state_e      state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             dir_q, dir_d;
  logic [7:0]       err_q, err_d;

  logic step, step_up, illegal, z_rise;

  quad_decoder u_dec (
    .clk     (I_CLK_100MHZ),
    .rst_n   (I_RST_N),
    .enc_a   (I_ENC_A),
    .enc_b   (I_ENC_B),
    .enc_z   (I_ENC_Z),
    .step    (step),
    .step_up (step_up),
    .illegal (illegal),
    .z_rise  (z_rise)
  );

  always_ff @(posedge I_CLK_100MHZ or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      pos_q   <= '0;
      dir_q   <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    err_d   = err_q;

    if (step) begin
      pos_d = step_up ? (pos_q + POS_W'(1)) : (pos_q - POS_W'(1));
      dir_d = step_up;
    end
    if (illegal && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end

    unique case (state_q)
      ST_SEEK: begin
        timer_d = timer_q + TMR_W'(1);
        if (I_ABORT) begin
          state_d = ST_IDLE;
        end else if (z_rise) begin
          // Index wins over a coincident step: the step is dropped entirely.
          state_d = ST_HOMED;
          pos_d   = '0;
          dir_d   = dir_q;
        end else if (timer_q == TMR_LAST) begin
          state_d = ST_FAULT;
        end
      end
      ST_FAULT: begin
        if (I_ABORT) begin
          state_d = ST_IDLE;
        end else if (I_HOME_REQ) begin
          state_d = ST_SEEK;
          timer_d = '0;
        end
      end
      default: begin
        if (I_HOME_REQ && !I_ABORT) begin
          state_d = ST_SEEK;
          timer_d = '0;
        end
      end
    endcase
  end

  assign O_POS     = pos_q;
  assign O_DIR     = dir_q;
  assign O_BUSY    = (state_q == ST_SEEK);
  assign O_HOMED   = (state_q == ST_HOMED);
  assign O_FAULT   = (state_q == ST_FAULT);
  assign O_STATE   = state_q;
  assign O_ERR_CNT = err_q;

endmodule

`default_nettype wire
